// File: rtl/load_store_unit.sv
// Load/store unit bridging a pipeline request port to a 32-bit word RAM, with read-modify-write
// for byte and half stores. Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout,
   output logic                  ram_write,
   output logic                  ram_read
);

   typedef enum logic [1:0] {StIdle, StAccess, StMergeWr, StResp} state_e;

   state_e                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic                  write_q;
   logic                  unsigned_q;
   logic [31:0]           wdata_q;
   logic [31:0]           merged_q;
   logic [31:0]           rdata_q;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [31:0]           load_data;
   logic [31:0]           merge_data;
   logic                  word_store;

   // size 2'b11 is treated as a word, so bit 1 alone marks a word access
   assign word_store = write_q && size_q[1];

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   logic err_q;
   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
   assign resp_err   = err_q;
`else
   assign resp_err   = 1'b0;
`endif

   always_comb begin
      byte_sel   = ram_dout[{addr_q[1:0], 3'b000} +: 8];
      half_sel   = ram_dout[{addr_q[1], 4'b0000} +: 16];
      load_data  = ram_dout;
      merge_data = ram_dout;
      if (!size_q[1]) begin
         if (size_q[0]) begin
            load_data = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
            merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end else begin
            load_data = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
            merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state      <= StIdle;
         addr_q     <= '0;
         size_q     <= 2'b00;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         merged_q   <= '0;
         rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  size_q     <= req_size;
                  write_q    <= req_write;
                  unsigned_q <= req_unsigned;
                  wdata_q    <= req_wdata;
                  rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  err_q      <= misaligned;
                  state      <= misaligned ? StResp : StAccess;
`else
                  state      <= StAccess;
`endif
               end
            end
            StAccess: begin
               if (!write_q) begin
                  rdata_q <= load_data;
                  state   <= StResp;
               end else if (size_q[1]) begin
                  state <= StResp;
               end else begin
                  merged_q <= merge_data;
                  state    <= StMergeWr;
               end
            end
            StMergeWr: state <= StResp;
            StResp:    if (resp_ready) state <= StIdle;
            default:   state <= StIdle;
         endcase
      end
   end

   // Strobes decode from the state register alone, so an async reset clears them at once
   assign req_ready  = (state == StIdle);
   assign resp_valid = (state == StResp);
   assign ram_read   = (state == StAccess) && !word_store;
   assign ram_write  = ((state == StAccess) && word_store) || (state == StMergeWr);
   assign ram_din    = (state == StMergeWr) ? merged_q :
                       (((state == StAccess) && word_store) ? wdata_q : '0);
   assign ram_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 32-word RAM whose word i starts as i*i.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;

   logic        Clock = 1'b0;
   logic        Resetn;
   logic        req_valid, req_write, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, ram_write, ram_read;
   logic [31:0] resp_rdata, ram_addr, ram_din, ram_dout;
   logic [31:0] mem [32];

   int checks   = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .ram_write   (ram_write),
      .ram_read    (ram_read)
   );

   // DATA_RAM: combinational read, write sampled on the rising edge
   initial for (int i = 0; i < 32; i++) mem[i] <= i * i;
   always @(posedge Clock) if (ram_write) mem[ram_addr[6:2]] <= ram_din;
   assign ram_dout = mem[ram_addr[6:2]];

   typedef struct {
      logic        write;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nw;
      int          nr;
      int          hold;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int edges = 0;
      int nw    = 0;
      int nr    = 0;
      @(negedge Clock);
      check($sformatf("v%0d_ready_before", idx), {31'b0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_write    = v.write;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      @(posedge Clock);
      edges = 1;
      #1 req_valid = 1'b0;
      while (!resp_valid && edges < 8) begin
         @(negedge Clock);
         if (ram_write) nw++;
         if (ram_read) nr++;
         @(posedge Clock);
         edges++;
         #1;
      end
      if (!resp_valid) begin
         failures++;
         checks++;
         $display("FAIL v%0d_timeout actual=no_resp required=resp_valid", idx);
         return;
      end
      if (!v.err) check($sformatf("v%0d_latency", idx), edges, v.lat);
      check($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
      check($sformatf("v%0d_err", idx), {31'b0, resp_err}, {31'b0, v.err});
      check($sformatf("v%0d_ram_writes", idx), nw, v.nw);
      check($sformatf("v%0d_ram_reads", idx), nr, v.nr);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge Clock);
         if (ram_write) nw++;
         check($sformatf("v%0d_hold%0d_valid", idx, h), {31'b0, resp_valid}, 32'd1);
         check($sformatf("v%0d_hold%0d_rdata", idx, h), resp_rdata, v.rdata);
         check($sformatf("v%0d_hold%0d_ready", idx, h), {31'b0, req_ready}, 32'd0);
      end
      @(negedge Clock);
      if (ram_write) nw++;
      resp_ready = 1'b1;
      @(posedge Clock);
      #1 resp_ready = 1'b0;
      check($sformatf("v%0d_resp_done", idx), {30'b0, resp_valid, req_ready}, 32'd1);
      check($sformatf("v%0d_ram_writes_total", idx), nw, v.nw);
   endtask

   initial begin
      Resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

      //               w     size   u     addr      wdata         rdata         err  lat nw nr hold
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h00000019, 1'b0, 2, 0, 1, 0};
      vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 0, 0};
      vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1, 0};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA, 32'h00000000, 1'b0, 3, 1, 1, 0};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'hDEADAAEF, 1'b0, 2, 0, 1, 0};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 1, 0};
      vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        32'h000000AA, 1'b0, 2, 0, 1, 0};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0C, 32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 1, 0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h00000000, 1'b0, 3, 1, 1, 0};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80010010, 1'b0, 2, 0, 1, 0};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2, 0, 1, 0};
      vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0, 2, 0, 1, 3};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h15, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 0};
      vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h09, 32'h00001234, 32'h00000000, 1'b1, 1, 0, 0, 0};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h00000004, 1'b0, 2, 0, 1, 0};
`else
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h15, 32'h0,        32'h00000019, 1'b0, 2, 0, 1, 0};
      vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h09, 32'h00001234, 32'h00000000, 1'b0, 3, 1, 1, 0};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h00001234, 1'b0, 2, 0, 1, 0};
`endif
      vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h1C, 32'h0,        32'h00000031, 1'b0, 2, 0, 1, 0};

      repeat (2) @(posedge Clock);
      #1;
      check("reset_outputs",
            {25'b0, req_ready, resp_valid, resp_err, ram_write, ram_read, 2'b0}, 32'h40);
      check("reset_rdata", resp_rdata, 32'h0);
      check("reset_ram_din", ram_din, 32'h0);
      @(negedge Clock);
      Resetn = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      check("mem_word3", mem[3], 32'hDEADAAEF);
      check("mem_word4", mem[4], 32'h80010010);

      // Reset asserted while the merged byte store is in MERGE_WR
      @(negedge Clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h55;
      @(posedge Clock);
      #1 req_valid = 1'b0;
      @(posedge Clock);
      #1 check("abort_in_merge_wr", {31'b0, ram_write}, 32'd1);
      #2 Resetn = 1'b0;
      #1;
      check("abort_ram_write_drop", {30'b0, ram_write, ram_read}, 32'd0);
      check("abort_handshake", {30'b0, req_ready, resp_valid}, 32'd2);
      check("abort_ram_din", ram_din, 32'h0);
      @(posedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      check("abort_word0", mem[0], 32'h0);
      check("abort_no_resp", {30'b0, req_ready, resp_valid}, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
